spi_accel_responder: RTL



---
 rtl/spi_accel_responder_pkg.sv | 29 ++
 rtl/spi_accel_responder_if.sv | 13 +
 rtl/spi_accel_responder_sync_edge.sv | 32 +++
 rtl/spi_accel_responder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/spi_accel_responder_pkg.sv
// Shared constants, FSM state type and register-map helpers for the
// accelerometer SPI responder.
package spi_accel_pkg;

    localparam logic [5:0] ADDR_DEVID   = 6'h00;
    localparam logic [5:0] ADDR_BW_RATE = 6'h2C;
    localparam logic [5:0] ADDR_DATAX0  = 6'h32;
    localparam logic [5:0] ADDR_DATAX1  = 6'h33;
    localparam logic [5:0] ADDR_DATAY0  = 6'h34;
    localparam logic [5:0] ADDR_DATAY1  = 6'h35;
    localparam logic [5:0] ADDR_DATAZ0  = 6'h36;
    localparam logic [5:0] ADDR_DATAZ1  = 6'h37;

    localparam int CMD_RW = 7;
    localparam int CMD_MB = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } state_e;

    // Device ID and the live axis samples are owned by the responder, not the master.
    function automatic logic is_writable(input logic [5:0] addr);
        return !((addr == ADDR_DEVID) || ((addr >= ADDR_DATAX0) && (addr <= ADDR_DATAZ1)));
    endfunction

endpackage

// File: rtl/spi_accel_responder_if.sv
// SPI pin bundle between the accelerometer driver (master) and the responder.
interface spi_accel_responder_if;
    // No valid/ready here: cs_n frames a transfer, sdi is sampled on sclk rising
    // edges, sdo changes on sclk falling edges and is only meaningful while sdo_oe=1.
    logic cs_n;
    logic sclk;
    logic sdi;
    logic sdo;
    logic sdo_oe;

    modport slave  (input  cs_n, sclk, sdi, output sdo, sdo_oe);
    modport master (output cs_n, sclk, sdi, input  sdo, sdo_oe);
endinterface

// File: rtl/spi_accel_responder_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin followed by a one-flop
// rise/fall detector on the synchronized level.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    logic              w_level;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync <= {STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign w_level = r_sync[STAGES-1];
    assign o_rise  = w_level & ~r_prev;
    assign o_fall  = ~w_level & r_prev;

endmodule

// File: rtl/spi_accel_responder.sv
// SPI mode-3 responder emulating a 3-axis accelerometer: 64-byte register map,
// single/multi-byte reads and writes, axis samples loaded from a parallel port.
module spi_accel_responder
    import spi_accel_pkg::*;
#(
    parameter logic [7:0] DEVID_VAL   = 8'hE5,
    parameter logic [7:0] BW_RATE_RST = 8'h0A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    spi_accel_responder_if.slave spi,
    input  logic signed [15:0]  i_sample_x,
    input  logic signed [15:0]  i_sample_y,
    input  logic signed [15:0]  i_sample_z,
    input  logic                i_sample_valid,
    output logic                o_wr_strobe,
    output logic [5:0]          o_wr_addr,
    output logic [7:0]          o_wr_data,
    output logic                o_frame_done,
    output state_e              o_dbg_state
);

    logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall, w_sdi;
    logic [SYNC_STAGES-1:0] r_sdi_sync;

    state_e     r_state, w_state_nxt;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic [5:0] r_addr;
    logic       r_mb;
    logic       r_sdo, r_sdo_oe;
    logic [7:0] r_regs [64];

    logic        r_pend_valid;
    logic [15:0] r_pend_x, r_pend_y, r_pend_z;

    logic [7:0]  w_shift_in, w_rd_data;
    logic [5:0]  w_addr_inc, w_rd_addr;
    logic        w_byte_done, w_load_rd, w_wr_byte;
    logic        w_apply_direct, w_apply;
    logic [15:0] w_new_x, w_new_y, w_new_z;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclk (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_async(spi.sclk),
        .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_async(spi.cs_n),
        .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    // Same depth as the sclk chain so sdi lines up with the detected sclk edge.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_sdi_sync <= '0;
        else          r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], spi.sdi};
    end
    assign w_sdi = r_sdi_sync[SYNC_STAGES-1];

    assign w_shift_in  = {r_shift[6:0], w_sdi};
    assign w_byte_done = w_sclk_rise && (r_bit_cnt == 3'd7);
    assign w_addr_inc  = r_mb ? (r_addr + 6'd1) : r_addr;
    assign w_rd_addr   = (r_state == CMD) ? w_shift_in[5:0] : w_addr_inc;
    assign w_rd_data   = (w_rd_addr == ADDR_DEVID) ? DEVID_VAL : r_regs[w_rd_addr];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_rd   = 1'b0;
        w_wr_byte   = 1'b0;
        if (w_cs_rise) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:  if (w_cs_fall) w_state_nxt = CMD;
                CMD:   if (w_byte_done) begin
                           w_state_nxt = w_shift_in[CMD_RW] ? RDATA : WDATA;
                           w_load_rd   = w_shift_in[CMD_RW];
                       end
                RDATA: w_load_rd = w_byte_done;
                WDATA: w_wr_byte = w_byte_done;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_addr       <= '0;
            r_mb         <= 1'b0;
            r_sdo        <= 1'b1;
            r_sdo_oe     <= 1'b0;
            o_wr_strobe  <= 1'b0;
            o_wr_addr    <= '0;
            o_wr_data    <= '0;
            o_frame_done <= 1'b0;
        end else begin
            o_wr_strobe  <= 1'b0;
            o_frame_done <= w_cs_rise;
            if (w_cs_rise || (r_state == IDLE)) begin
                r_bit_cnt <= '0;
                r_sdo     <= 1'b1;
                r_sdo_oe  <= 1'b0;
            end else begin
                if (w_sclk_rise) r_bit_cnt <= r_bit_cnt + 3'd1;
                case (r_state)
                    CMD: if (w_sclk_rise) begin
                        r_shift <= w_shift_in;
                        if (w_byte_done) begin
                            r_addr <= w_shift_in[5:0];
                            r_mb   <= w_shift_in[CMD_MB];
                        end
                        if (w_load_rd) begin
                            r_shift  <= w_rd_data;
                            r_sdo_oe <= 1'b1;
                        end
                    end
                    RDATA: begin
                        if (w_sclk_fall) begin
                            r_sdo   <= r_shift[7];
                            r_shift <= {r_shift[6:0], 1'b0};
                        end
                        if (w_load_rd) begin
                            r_addr  <= w_addr_inc;
                            r_shift <= w_rd_data;
                        end
                    end
                    WDATA: if (w_sclk_rise) begin
                        r_shift <= w_shift_in;
                        if (w_wr_byte) begin
                            o_wr_strobe <= 1'b1;
                            o_wr_addr   <= r_addr;
                            o_wr_data   <= w_shift_in;
                            r_addr      <= w_addr_inc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Samples arriving mid-frame are parked until cs_n rises so a burst read stays coherent.
    assign w_apply_direct = i_sample_valid && (w_cs_rise || ((r_state == IDLE) && !w_cs_fall));
    assign w_apply        = w_apply_direct || (w_cs_rise && r_pend_valid);
    assign w_new_x        = i_sample_valid ? i_sample_x : r_pend_x;
    assign w_new_y        = i_sample_valid ? i_sample_y : r_pend_y;
    assign w_new_z        = i_sample_valid ? i_sample_z : r_pend_z;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 64; i++) r_regs[i] <= 8'h00;
            r_regs[ADDR_BW_RATE] <= BW_RATE_RST;
            r_pend_valid <= 1'b0;
            r_pend_x     <= '0;
            r_pend_y     <= '0;
            r_pend_z     <= '0;
        end else begin
            if (w_wr_byte && is_writable(r_addr)) r_regs[r_addr] <= w_shift_in;
            if (w_apply) begin
                r_regs[ADDR_DATAX0] <= w_new_x[7:0];
                r_regs[ADDR_DATAX1] <= w_new_x[15:8];
                r_regs[ADDR_DATAY0] <= w_new_y[7:0];
                r_regs[ADDR_DATAY1] <= w_new_y[15:8];
                r_regs[ADDR_DATAZ0] <= w_new_z[7:0];
                r_regs[ADDR_DATAZ1] <= w_new_z[15:8];
            end
            if (w_cs_rise) begin
                r_pend_valid <= 1'b0;
            end else if (i_sample_valid && !w_apply_direct) begin
                r_pend_valid <= 1'b1;
                r_pend_x     <= i_sample_x;
                r_pend_y     <= i_sample_y;
                r_pend_z     <= i_sample_z;
            end
        end
    end

    assign spi.sdo     = r_sdo;
    assign spi.sdo_oe  = r_sdo_oe;
    assign o_dbg_state = r_state;

endmodule
